// File: rtl/register_file_16x32.sv
// 16 x 32-bit register file: three combinational read ports, one general
// write port and a dedicated R15 (program counter) load path.
module register_file_16x32 #(
    parameter int unsigned BYPASS   = 0,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LE,
    input  logic [3:0]  WSel,
    input  logic [31:0] PW,
    input  logic        PCLd,
    input  logic [31:0] PCIn,
    input  logic [3:0]  SA,
    input  logic [3:0]  SB,
    input  logic [3:0]  SD,
    output logic [31:0] PA,
    output logic [31:0] PB,
    output logic [31:0] PD,
    output logic [31:0] PCOut
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] view [NUM_REGS];

    // Storage update; the general write is issued last so it wins an R15 collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[ADDR_W'(i)] <= (i == NUM_REGS - 1) ? PC_RESET : '0;
            end
        end else begin
            if (PCLd) begin
                regs[PC_IDX] <= PCIn;
            end
            if (LE) begin
                regs[WSel] <= PW;
            end
        end
    end

    // Read-side view of the file, optionally with this cycle's pending writes forwarded.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            view[ADDR_W'(i)] = regs[ADDR_W'(i)];
        end
        if ((BYPASS != 0) && !reset) begin
            if (PCLd) begin
                view[PC_IDX] = PCIn;
            end
            if (LE) begin
                view[WSel] = PW;
            end
        end
    end

    assign PA    = view[SA];
    assign PB    = view[SB];
    assign PD    = view[SD];
    assign PCOut = regs[PC_IDX];

endmodule

// File: tb/tb_register_file_16x32.sv
// Self-checking bench: one non-forwarding and one forwarding instance share
// stimulus and are compared against a behavioural register-array model.
module tb_register_file_16x32;

    localparam logic [31:0] PCR = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        LE = 1'b0;
    logic [3:0]  WSel = '0;
    logic [31:0] PW = '0;
    logic        PCLd = 1'b0;
    logic [31:0] PCIn = '0;
    logic [3:0]  SA = '0, SB = '0, SD = '0;
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [31:0] pd [2];
    logic [31:0] pco [2];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [16];

    always #5 clk = ~clk;

    register_file_16x32 #(.BYPASS(0), .PC_RESET(PCR)) dut0 (
        .clk(clk), .reset(reset), .LE(LE), .WSel(WSel), .PW(PW),
        .PCLd(PCLd), .PCIn(PCIn), .SA(SA), .SB(SB), .SD(SD),
        .PA(pa[0]), .PB(pb[0]), .PD(pd[0]), .PCOut(pco[0]));

    register_file_16x32 #(.BYPASS(1), .PC_RESET(PCR)) dut1 (
        .clk(clk), .reset(reset), .LE(LE), .WSel(WSel), .PW(PW),
        .PCLd(PCLd), .PCIn(PCIn), .SA(SA), .SB(SB), .SD(SD),
        .PA(pa[1]), .PB(pb[1]), .PD(pd[1]), .PCOut(pco[1]));

    // Expected read value for a select under the current inputs.
    function automatic logic [31:0] exp_rd(input logic [3:0] sel, input int byp);
        if (byp != 0 && !reset) begin
            if (LE && sel == WSel) return PW;
            if (PCLd && sel == 4'hF) return PCIn;
        end
        return model[sel];
    endfunction

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic tick();
        logic [31:0] nxt [16];
        for (int i = 0; i < 16; i++) nxt[i] = model[i];
        if (reset) begin
            for (int i = 0; i < 16; i++) nxt[i] = (i == 15) ? PCR : 32'h0;
        end else begin
            if (LE) nxt[WSel] = PW;
            if (PCLd && !(LE && WSel == 4'hF)) nxt[15] = PCIn;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) model[i] = nxt[i];
    endtask

    task automatic test_reset();
        reset = 1'b1; LE = 1'b0; PCLd = 1'b0;
        tick();
        reset = 1'b0;
        for (int s = 0; s < 16; s++) begin
            SA = 4'(s); SB = 4'(s); SD = 4'(s);
            #1;
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (pa[b] !== ((s == 15) ? PCR : 32'h0)) begin
                    miscompares++;
                    $display("FAIL reset_sweep byp=%0d r%0d got %h want %h", b, s, pa[b], (s == 15) ? PCR : 32'h0);
                end
                vectors++;
                if (pco[b] !== PCR) begin
                    miscompares++;
                    $display("FAIL reset_pcout byp=%0d got %h want %h", b, pco[b], PCR);
                end
            end
        end
    endtask

    task automatic test_write_sweep();
        LE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            WSel = 4'(i); PW = 32'hA5A5_0000 + 32'(i);
            tick();
        end
        LE = 1'b0;
        for (int i = 0; i < 16; i++) begin
            SA = 4'(i); SB = 4'(15 - i); SD = 4'((i + 5) % 16);
            #1;
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (pa[b] !== 32'hA5A5_0000 + 32'(i)) begin
                    miscompares++;
                    $display("FAIL sweep_pa byp=%0d r%0d got %h want %h", b, i, pa[b], 32'hA5A5_0000 + 32'(i));
                end
                vectors++;
                if (pb[b] !== 32'hA5A5_0000 + 32'(15 - i)) begin
                    miscompares++;
                    $display("FAIL sweep_pb byp=%0d r%0d got %h want %h", b, 15 - i, pb[b], 32'hA5A5_0000 + 32'(15 - i));
                end
                vectors++;
                if (pd[b] !== 32'hA5A5_0000 + 32'((i + 5) % 16)) begin
                    miscompares++;
                    $display("FAIL sweep_pd byp=%0d r%0d got %h want %h", b, (i + 5) % 16, pd[b], 32'hA5A5_0000 + 32'((i + 5) % 16));
                end
            end
        end
    endtask

    task automatic test_pc_load();
        LE = 1'b0; PCLd = 1'b1; PCIn = 32'h0000_0004;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (pco[b] !== 32'h0000_0004) begin
                    miscompares++;
                    $display("FAIL pc_load byp=%0d cycle%0d got %h want %h", b, c, pco[b], 32'h4);
                end
            end
        end
        PCLd = 1'b0;
        for (int i = 0; i < 15; i++) begin
            SD = 4'(i);
            #1;
            for (int b = 0; b < 2; b++) begin
                vectors++;
                if (pd[b] !== 32'hA5A5_0000 + 32'(i)) begin
                    miscompares++;
                    $display("FAIL pc_load_keep byp=%0d r%0d got %h want %h", b, i, pd[b], 32'hA5A5_0000 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_collision();
        LE = 1'b1; WSel = 4'hF; PW = 32'h0000_1000; PCLd = 1'b1; PCIn = 32'h0000_0008; SA = 4'hF;
        #1;
        vectors++;
        if (pa[0] !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL collide_pre byp=0 got %h want %h", pa[0], 32'h4);
        end
        vectors++;
        if (pa[1] !== 32'h0000_1000) begin
            miscompares++;
            $display("FAIL collide_pre byp=1 got %h want %h", pa[1], 32'h1000);
        end
        tick();
        LE = 1'b0; PCLd = 1'b0;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (pco[b] !== 32'h0000_1000) begin
                miscompares++;
                $display("FAIL collide_pcout byp=%0d got %h want %h", b, pco[b], 32'h1000);
            end
        end
    endtask

    task automatic test_bypass();
        reset = 1'b1; tick(); reset = 1'b0;
        LE = 1'b1; WSel = 4'd3; PW = 32'hDEAD_BEEF; SA = 4'd3;
        #1;
        vectors++;
        if (pa[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_pre byp=0 got %h want %h", pa[0], 32'h0);
        end
        vectors++;
        if (pa[1] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL bypass_pre byp=1 got %h want %h", pa[1], 32'hDEAD_BEEF);
        end
        tick();
        LE = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (pa[b] !== 32'hDEAD_BEEF) begin
                miscompares++;
                $display("FAIL bypass_post byp=%0d got %h want %h", b, pa[b], 32'hDEAD_BEEF);
            end
        end
        PCLd = 1'b1; PCIn = 32'h1234_5678; SB = 4'hF;
        #1;
        vectors++;
        if (pb[0] !== PCR) begin
            miscompares++;
            $display("FAIL pcin_fwd byp=0 got %h want %h", pb[0], PCR);
        end
        vectors++;
        if (pb[1] !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL pcin_fwd byp=1 got %h want %h", pb[1], 32'h1234_5678);
        end
        tick();
        PCLd = 1'b0;
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; LE = 1'b1; WSel = 4'd5; PW = 32'hFFFF_FFFF; PCLd = 1'b1; PCIn = 32'h0000_0044;
        tick();
        reset = 1'b0; LE = 1'b0; PCLd = 1'b0; SA = 4'd5;
        #1;
        for (int b = 0; b < 2; b++) begin
            vectors++;
            if (pa[b] !== 32'h0) begin
                miscompares++;
                $display("FAIL rst_prio_r5 byp=%0d got %h want %h", b, pa[b], 32'h0);
            end
            vectors++;
            if (pco[b] !== PCR) begin
                miscompares++;
                $display("FAIL rst_prio_pc byp=%0d got %h want %h", b, pco[b], PCR);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(39) == 0);
            LE    = $urandom_range(1) == 1;
            WSel  = 4'($urandom_range(15));
            PW    = $urandom;
            PCLd  = $urandom_range(2) == 0;
            PCIn  = $urandom;
            SA    = ($urandom_range(3) == 0) ? WSel : 4'($urandom_range(15));
            SB    = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom_range(15));
            SD    = ($urandom_range(3) == 0) ? WSel : 4'($urandom_range(15));
            #1;
            for (int b = 0; b < 2; b++) begin
                e = exp_rd(SA, b);
                vectors++;
                if (pa[b] !== e) begin
                    miscompares++;
                    $display("FAIL rand_pa byp=%0d n=%0d got %h want %h", b, n, pa[b], e);
                end
                e = exp_rd(SB, b);
                vectors++;
                if (pb[b] !== e) begin
                    miscompares++;
                    $display("FAIL rand_pb byp=%0d n=%0d got %h want %h", b, n, pb[b], e);
                end
                e = exp_rd(SD, b);
                vectors++;
                if (pd[b] !== e) begin
                    miscompares++;
                    $display("FAIL rand_pd byp=%0d n=%0d got %h want %h", b, n, pd[b], e);
                end
                vectors++;
                if (pco[b] !== model[15]) begin
                    miscompares++;
                    $display("FAIL rand_pcout byp=%0d n=%0d got %h want %h", b, n, pco[b], model[15]);
                end
            end
            tick();
        end
        reset = 1'b0; LE = 1'b0; PCLd = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        #2;
        test_reset();
        test_write_sweep();
        test_pc_load();
        test_collision();
        test_bypass();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
